// File: rtl/bp_io_cmd_router.sv
// ============================================================================
//  Module   : bp_io_cmd_router
//  Purpose  : N-target IO command router with address decode and in-order
//             response return through an outstanding-destination FIFO.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bp_io_cmd_router #(
    parameter int msg_width_p       = 120,
    parameter int addr_width_p      = 40,
    parameter int addr_offset_p     = 0,
    parameter int num_targets_p     = 4,
    parameter logic [num_targets_p*addr_width_p-1:0] target_base_p = '0,
    parameter logic [num_targets_p*addr_width_p-1:0] target_mask_p = '0,
    parameter int default_target_p  = 0,
    parameter int max_outstanding_p = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [msg_width_p-1:0]                   cmd_i,
    input  logic                                     cmd_v_i,
    output logic                                     cmd_ready_and_o,
    output logic [msg_width_p-1:0]                   resp_o,
    output logic                                     resp_v_o,
    input  logic                                     resp_yumi_i,
    output logic [msg_width_p-1:0]                   tgt_cmd_o,
    output logic [num_targets_p-1:0]                 tgt_cmd_v_o,
    input  logic [num_targets_p-1:0]                 tgt_cmd_ready_and_i,
    input  logic [num_targets_p*msg_width_p-1:0]     tgt_resp_i,
    input  logic [num_targets_p-1:0]                 tgt_resp_v_i,
    output logic [num_targets_p-1:0]                 tgt_resp_yumi_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o
);

    localparam int SEL_W = $clog2(num_targets_p);
    localparam int PTR_W = $clog2(max_outstanding_p);
    localparam int CNT_W = $clog2(max_outstanding_p+1);
    localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(max_outstanding_p);
    localparam logic [num_targets_p-1:0] ONE_HOT0 = {{(num_targets_p-1){1'b0}}, 1'b1};

    logic [addr_width_p-1:0] addr;
    logic [SEL_W-1:0]        sel;
    logic [SEL_W-1:0]        head;
    logic                    found;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    logic [SEL_W-1:0] fifo_q [max_outstanding_p];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign addr = cmd_i[addr_offset_p +: addr_width_p];

    // Lowest-indexed matching target wins; no match falls back to the default.
    always_comb begin
        sel   = SEL_W'(default_target_p);
        found = 1'b0;
        for (int k = 0; k < num_targets_p; k++) begin
            if (!found && ((addr & target_mask_p[k*addr_width_p +: addr_width_p])
                           == target_base_p[k*addr_width_p +: addr_width_p])) begin
                sel   = SEL_W'(k);
                found = 1'b1;
            end
        end
    end

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    assign tgt_cmd_o       = cmd_i;
    assign tgt_cmd_v_o     = (reset_n_i && cmd_v_i && !full) ? (ONE_HOT0 << sel) : '0;
    assign cmd_ready_and_o = reset_n_i & ~full & tgt_cmd_ready_and_i[sel];
    assign push            = cmd_v_i & cmd_ready_and_o;

    assign resp_o          = tgt_resp_i[head*msg_width_p +: msg_width_p];
    assign resp_v_o        = reset_n_i & ~empty & tgt_resp_v_i[head];
    assign pop             = reset_n_i & ~empty & resp_yumi_i;
    assign tgt_resp_yumi_o = pop ? (ONE_HOT0 << head) : '0;

    assign outstanding_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Destination storage needs no reset: push is already gated by reset.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= sel;
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!resp_yumi_i || resp_v_o);
            assert ($onehot0(tgt_resp_yumi_o));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_io_cmd_router.sv
// ============================================================================
//  Module   : tb_bp_io_cmd_router
//  Purpose  : Scoreboard bench for bp_io_cmd_router (decode, ordering, full,
//             backpressure, mid-flight reset).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_io_cmd_router;

    localparam int MW = 120;
    localparam int AW = 40;
    localparam int NT = 4;
    localparam logic [NT*AW-1:0] BASE = {40'h00_0000_0040, 40'h00_0030_0000,
                                         40'h00_0020_0000, 40'h00_0010_0000};
    localparam logic [NT*AW-1:0] MASK = {40'h00_0000_00F0, 40'h00_00F0_0000,
                                         40'h00_00F0_0000, 40'h00_00F0_0000};

    logic             clk = 1'b0;
    logic             reset_n;
    logic [MW-1:0]    cmd;
    logic             cmd_v;
    logic             cmd_rdy;
    logic [MW-1:0]    resp;
    logic             resp_v;
    logic             resp_yumi;
    logic             yumi_en;
    logic [MW-1:0]    tgt_cmd;
    logic [NT-1:0]    tgt_cmd_v;
    logic [NT-1:0]    tgt_rdy;
    logic [NT*MW-1:0] tgt_resp;
    logic [NT-1:0]    tgt_resp_v;
    logic [NT-1:0]    tgt_resp_yumi;
    logic [3:0]       outstanding;

    int n_cmp = 0;
    int n_err = 0;
    logic [MW-1:0] exp_q [$];

    always #5 clk = ~clk;

    assign resp_yumi = resp_v & yumi_en;

    bp_io_cmd_router #(
        .msg_width_p(MW), .addr_width_p(AW), .addr_offset_p(0), .num_targets_p(NT),
        .target_base_p(BASE), .target_mask_p(MASK), .default_target_p(2),
        .max_outstanding_p(8)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_ready_and_o(cmd_rdy),
        .resp_o(resp), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
        .tgt_cmd_o(tgt_cmd), .tgt_cmd_v_o(tgt_cmd_v), .tgt_cmd_ready_and_i(tgt_rdy),
        .tgt_resp_i(tgt_resp), .tgt_resp_v_i(tgt_resp_v), .tgt_resp_yumi_o(tgt_resp_yumi),
        .outstanding_o(outstanding)
    );

    function automatic logic [MW-1:0] rsp(input logic [15:0] tag);
        return {8'hA5, 96'h0, tag};
    endfunction

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // One clock; targets drop a response the DUT consumed at this edge.
    task automatic tick();
        logic [NT-1:0] y;
        @(negedge clk);
        y = tgt_resp_yumi;
        @(posedge clk);
        #1;
        tgt_resp_v = tgt_resp_v & ~y;
    endtask

    task automatic set_resp(input int k, input logic [15:0] tag);
        tgt_resp[k*MW +: MW] = rsp(tag);
        tgt_resp_v[k] = 1'b1;
    endtask

    task automatic send_cmd(input string nm, input logic [AW-1:0] a,
                            input logic [NT-1:0] exp_oh, input logic [15:0] tag);
        bit acc = 1'b0;
        cmd   = {64'(tag), 16'h0, a};
        cmd_v = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (cmd_rdy) begin
                chk(nm, {116'h0, tgt_cmd_v}, {116'h0, exp_oh});
                exp_q.push_back(rsp(tag));
                acc = 1'b1;
            end
            tick();
        end
        cmd_v = 1'b0;
        if (!acc) chk({nm, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_out(input string nm, input logic [3:0] v);
        for (int i = 0; i < 100; i++) begin
            if (outstanding == v) break;
            tick();
        end
        chk(nm, {116'h0, outstanding}, {116'h0, v});
    endtask

    // Scoreboard monitor: every response handshake is checked in order.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_v && resp_yumi) begin
                if (exp_q.size() == 0) chk("resp_unexpected", resp, '0 - 1);
                else                   chk("resp_order", resp, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        cmd        = '0;
        cmd_v      = 1'b1;
        yumi_en    = 1'b1;
        tgt_rdy    = '1;
        tgt_resp   = '0;
        tgt_resp_v = '1;

        // Reset state with active-looking inputs
        @(posedge clk); #1;
        tick(); #1;
        chk("rst_ready",     {119'h0, cmd_rdy}, 0);
        chk("rst_tgt_cmd_v", {116'h0, tgt_cmd_v}, 0);
        chk("rst_resp_v",    {119'h0, resp_v}, 0);
        chk("rst_yumi",      {116'h0, tgt_resp_yumi}, 0);
        chk("rst_out",       {116'h0, outstanding}, 0);
        cmd_v      = 1'b0;
        tgt_resp_v = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // Decode: overlap, default, plain hits
        send_cmd("dec_overlap_t1", 40'h00_0020_0040, 4'b0010, 16'd1);
        send_cmd("dec_default_t2", 40'h00_0050_0000, 4'b0100, 16'd2);
        send_cmd("dec_t3",         40'h00_0000_0040, 4'b1000, 16'd3);
        send_cmd("dec_t0",         40'h00_0010_0000, 4'b0001, 16'd4);
        #1 chk("dec_out4", {116'h0, outstanding}, 4);
        set_resp(0, 16'd4); set_resp(1, 16'd1); set_resp(2, 16'd2); set_resp(3, 16'd3);
        wait_out("dec_drain", 0);

        // Ordering: T0 answers first but must wait behind T2
        send_cmd("ord_t2", 40'h00_0030_0000, 4'b0100, 16'd5);
        send_cmd("ord_t0", 40'h00_0010_0000, 4'b0001, 16'd6);
        set_resp(0, 16'd6);
        tick(); tick(); tick(); #1;
        chk("ord_held_v",  {119'h0, resp_v}, 0);
        chk("ord_held_out", {116'h0, outstanding}, 2);
        set_resp(2, 16'd5);
        tick(); #1 chk("ord_out1", {116'h0, outstanding}, 1);
        tick(); #1 chk("ord_out0", {116'h0, outstanding}, 0);

        // Full: 8 outstanding, then pop and new command in the same cycle
        yumi_en = 1'b0;
        for (int t = 7; t <= 14; t++)
            send_cmd("full_fill", 40'h00_0020_0000, 4'b0010, 16'(t));
        #1 chk("full_out8", {116'h0, outstanding}, 8);
        cmd   = {64'd15, 16'h0, 40'h00_0020_0000};
        cmd_v = 1'b1;
        #1 chk("full_ready0", {119'h0, cmd_rdy}, 0);
        set_resp(1, 16'd7);
        yumi_en = 1'b1;
        #1;
        chk("full_pop_ready0", {119'h0, cmd_rdy}, 0);
        chk("full_pop_resp_v", {119'h0, resp_v}, 1);
        tick();
        yumi_en = 1'b0;
        #1;
        chk("full_after_pop_out", {116'h0, outstanding}, 7);
        chk("full_after_pop_rdy", {119'h0, cmd_rdy}, 1);
        exp_q.push_back(rsp(16'd15));
        tick();
        cmd_v = 1'b0;
        #1 chk("full_out8_again", {116'h0, outstanding}, 8);
        yumi_en = 1'b1;
        for (int t = 8; t <= 15; t++) begin
            set_resp(1, 16'(t));
            for (int i = 0; i < 20; i++) begin
                if (!tgt_resp_v[1]) break;
                tick();
            end
        end
        wait_out("full_drain", 0);

        // Backpressure from the selected target
        tgt_rdy = 4'b1011;
        cmd     = {64'd16, 16'h0, 40'h00_0030_0000};
        cmd_v   = 1'b1;
        #1 chk("bp_tgt_cmd_v", {116'h0, tgt_cmd_v}, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready0", {119'h0, cmd_rdy}, 0);
            chk("bp_out0",   {116'h0, outstanding}, 0);
            tick();
        end
        tgt_rdy = '1;
        #1 chk("bp_ready1", {119'h0, cmd_rdy}, 1);
        exp_q.push_back(rsp(16'd16));
        tick();
        cmd_v = 1'b0;
        #1 chk("bp_out1", {116'h0, outstanding}, 1);

        // Reset with three commands in flight
        send_cmd("rst_fill_t0", 40'h00_0010_0000, 4'b0001, 16'd17);
        send_cmd("rst_fill_t3", 40'h00_0000_0040, 4'b1000, 16'd18);
        #1 chk("rst_mid_out3", {116'h0, outstanding}, 3);
        set_resp(0, 16'd17);
        yumi_en = 1'b0;
        cmd_v   = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        cmd_v   = 1'b0;
        yumi_en = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_out",    {116'h0, outstanding}, 0);
        chk("rst_mid_cmd_v",  {116'h0, tgt_cmd_v}, 0);
        chk("rst_mid_resp_v", {119'h0, resp_v}, 0);
        chk("rst_mid_yumi",   {116'h0, tgt_resp_yumi}, 0);
        tgt_resp_v = '0;

        // Normal traffic after reset
        send_cmd("post_t3", 40'h00_0000_0040, 4'b1000, 16'd19);
        set_resp(3, 16'd19);
        wait_out("post_drain", 0);
        tick(); tick();
        chk("sb_empty", 120'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
